// File: rtl/data_ram_responder_pkg.sv
// Shared constants for the MEM-stage data RAM responder and the CPU control unit:
// RAM_CTRL field positions, access size codes and responder FSM encodings.
package data_ram_responder_pkg;

  localparam int CTRL_EN_BIT = 3;
  localparam int CTRL_RW_BIT = 2;
  localparam int CTRL_SZ_MSB = 1;
  localparam int CTRL_SZ_LSB = 0;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } ram_state_e;

  // Misaligned halfword/word or the reserved size code.
  function automatic logic access_error(input logic [1:0] size, input logic [1:0] addr_lo);
    logic err;
    case (size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = addr_lo[0];
      SZ_WORD: err = (addr_lo != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/data_ram_responder_ram_byte_array.sv
// 256 x 8 data storage. Four byte lanes starting at addr_i; lane 3 (MSB of the
// 32-bit bus) is the byte at addr_i, lane 0 the byte at addr_i+3 (big-endian).
// Lane addresses wrap modulo 256.
module ram_byte_array (
  input  logic        clk_i,
  input  logic [7:0]  addr_i,
  input  logic [3:0]  we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o
);

  logic [7:0] mem [256];

  // Synchronous per-lane write; contents are intentionally never reset.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i[3-i]) begin
        mem[addr_i + 8'(i)] <= wdata_i[31-8*i -: 8];
      end
    end
  end

  // Combinational 4-byte read, byte at addr_i in the MSB.
  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < 4; i++) begin
      rdata_o[31-8*i -: 8] = mem[addr_i + 8'(i)];
    end
  end

endmodule

// File: rtl/data_ram_responder.sv
// MEM-stage data RAM responder: accepts one access at a time, waits LATENCY
// cycles, then commits the store or returns zero-extended load data with a
// one-cycle ACK. Misaligned or reserved-size accesses respond with ERR.
//
// state   | meaning
// IDLE    | ready; a qualifying REQ is accepted at the next edge
// WAIT    | wait states, counter counts down LATENCY-1 .. 0
// RESP    | ACK cycle; store committed / DO loaded at the edge entering it
module data_ram_responder
  import data_ram_responder_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        REQ,
  input  logic [3:0]  RAM_CTRL,
  input  logic [7:0]  A,
  input  logic [31:0] DI,
  output logic [31:0] DO,
  output logic        ACK,
  output logic        BUSY,
  output logic        ERR
);

  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  ram_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  addr_q;
  logic [31:0] wdata_q;
  logic        rw_q;
  logic [1:0]  size_q;
  logic [31:0] do_q, do_d;
  logic        err_q, err_d;

  logic        accept;
  logic        enter_resp;
  logic [7:0]  sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_rw;
  logic [1:0]  sel_size;
  logic        acc_err;
  logic [3:0]  ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  ram_byte_array u_ram (
    .clk_i   (Clk),
    .addr_i  (sel_addr),
    .we_i    (ram_we),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // Next state, wait counter, access decode, lane steering and load extension.
  // With LATENCY=0 RESP is entered straight from IDLE, so the live inputs are
  // steered to the RAM instead of the captured request.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    do_d      = do_q;
    err_d     = 1'b0;
    ram_we    = 4'b0000;
    ram_wdata = '0;

    accept = (state_q == ST_IDLE) && REQ && RAM_CTRL[CTRL_EN_BIT];

    if (state_q == ST_IDLE) begin
      sel_addr  = A;
      sel_wdata = DI;
      sel_rw    = RAM_CTRL[CTRL_RW_BIT];
      sel_size  = RAM_CTRL[CTRL_SZ_MSB:CTRL_SZ_LSB];
    end else begin
      sel_addr  = addr_q;
      sel_wdata = wdata_q;
      sel_rw    = rw_q;
      sel_size  = size_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    enter_resp = (state_d == ST_RESP) && Rst;
    acc_err    = access_error(sel_size, sel_addr[1:0]);

    case (sel_size)
      SZ_WORD: ram_wdata = sel_wdata;
      SZ_HALF: ram_wdata = {sel_wdata[15:0], 16'h0000};
      default: ram_wdata = {sel_wdata[7:0], 24'h000000};
    endcase

    if (enter_resp) begin
      err_d = acc_err;
      if (acc_err) begin
        do_d = '0;
      end else if (sel_rw) begin
        case (sel_size)
          SZ_WORD: ram_we = 4'b1111;
          SZ_HALF: ram_we = 4'b1100;
          default: ram_we = 4'b1000;
        endcase
      end else begin
        case (sel_size)
          SZ_WORD: do_d = ram_rdata;
          SZ_HALF: do_d = {16'h0000, ram_rdata[31:16]};
          default: do_d = {24'h000000, ram_rdata[31:24]};
        endcase
      end
    end
  end

  // State, counter, response registers and request capture.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      do_q    <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      size_q  <= SZ_BYTE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      do_q    <= do_d;
      err_q   <= err_d;
      if (accept) begin
        addr_q  <= A;
        wdata_q <= DI;
        rw_q    <= RAM_CTRL[CTRL_RW_BIT];
        size_q  <= RAM_CTRL[CTRL_SZ_MSB:CTRL_SZ_LSB];
      end
    end
  end

  // BUSY stalls the pipeline from request through WAIT, dropping on the ACK cycle.
  assign ACK  = (state_q == ST_RESP);
  assign ERR  = err_q && ACK;
  assign DO   = do_q;
  assign BUSY = Rst && ((state_q == ST_WAIT) ||
                        ((state_q == ST_IDLE) && REQ && RAM_CTRL[CTRL_EN_BIT]));

endmodule

// File: tb/tb_data_ram_responder.sv
module tb_data_ram_responder;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        req2, req0;
  logic [3:0]  ctrl2, ctrl0;
  logic [7:0]  a2, a0;
  logic [31:0] di2, di0;
  logic [31:0] do2, do0;
  logic        ack2, ack0, busy2, busy0, err2, err0;

  int vec = 0;
  int bad = 0;
  int cyc = 0;
  logic mon_en = 1'b0;

  typedef struct {
    int          cyc;
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t q2[$];
  exp_t q0[$];
  exp_t m2, m0;

  localparam logic W = 1'b1;  // store
  localparam logic R = 1'b0;  // load
  localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10, SX = 2'b11;

  data_ram_responder #(.LATENCY(2)) dut2 (
    .Clk(clk), .Rst(rst_b), .REQ(req2), .RAM_CTRL(ctrl2), .A(a2), .DI(di2),
    .DO(do2), .ACK(ack2), .BUSY(busy2), .ERR(err2)
  );

  data_ram_responder #(.LATENCY(0)) dut0 (
    .Clk(clk), .Rst(rst_b), .REQ(req0), .RAM_CTRL(ctrl0), .A(a0), .DI(di0),
    .DO(do0), .ACK(ack0), .BUSY(busy0), .ERR(err0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: pop an expectation on every ACK.
  always @(negedge clk) begin
    if (mon_en && rst_b) begin
      if (ack2) begin
        if (q2.size() == 0) begin
          vec++; bad++;
          $display("FAIL l2_unexpected_ack: ACK seen at cycle %0d with nothing outstanding", cyc);
        end else begin
          m2 = q2.pop_front();
          chk("l2_ack_cycle", cyc, m2.cyc);
          chk("l2_do", do2, m2.d);
          chk("l2_err", {31'b0, err2}, {31'b0, m2.e});
          chk("l2_busy_in_resp", {31'b0, busy2}, 32'd0);
        end
      end else begin
        chk("l2_err_without_ack", {31'b0, err2}, 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && rst_b) begin
      if (ack0) begin
        if (q0.size() == 0) begin
          vec++; bad++;
          $display("FAIL l0_unexpected_ack: ACK seen at cycle %0d with nothing outstanding", cyc);
        end else begin
          m0 = q0.pop_front();
          chk("l0_ack_cycle", cyc, m0.cyc);
          chk("l0_do", do0, m0.d);
          chk("l0_err", {31'b0, err0}, {31'b0, m0.e});
          chk("l0_busy_in_resp", {31'b0, busy0}, 32'd0);
        end
      end else begin
        chk("l0_err_without_ack", {31'b0, err0}, 32'd0);
      end
    end
  end

  // One access on the LATENCY=2 instance; ACK expected in the 3rd cycle after acceptance.
  task automatic issue2(input logic rw, input logic [1:0] sz, input logic [7:0] a,
                        input logic [31:0] di, input logic [31:0] xd, input logic xe);
    exp_t e;
    req2 = 1'b1; ctrl2 = {1'b1, rw, sz}; a2 = a; di2 = di;
    #1 chk("l2_busy_on_req", {31'b0, busy2}, 32'd1);
    tick();
    e.cyc = cyc + 2; e.d = xd; e.e = xe;
    q2.push_back(e);
    req2 = 1'b0; ctrl2 = '0; a2 = '0; di2 = '0;
    chk("l2_busy_in_wait", {31'b0, busy2}, 32'd1);
    repeat (3) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    rst_b = 1'b0;
    req2 = 1'b1; ctrl2 = 4'b1010; a2 = 8'h10; di2 = '0;
    req0 = 1'b1; ctrl0 = 4'b1010; a0 = 8'h10; di0 = '0;
    repeat (3) tick();
    // Reset state with a qualifying request held high.
    chk("rst_do", do2, 32'd0);
    chk("rst_ack", {31'b0, ack2}, 32'd0);
    chk("rst_busy", {31'b0, busy2}, 32'd0);
    chk("rst_err", {31'b0, err2}, 32'd0);
    chk("rst_do_l0", do0, 32'd0);
    chk("rst_busy_l0", {31'b0, busy0}, 32'd0);
    req2 = 1'b0; ctrl2 = '0; req0 = 1'b0; ctrl0 = '0;
    rst_b = 1'b1;
    tick();
    mon_en = 1'b1;
    tick();

    issue2(W, SW, 8'h10, 32'hDEADBEEF, 32'h00000000, 1'b0);
    issue2(R, SW, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0);
    issue2(R, SB, 8'h11, 32'h0,        32'h000000AD, 1'b0);
    issue2(R, SH, 8'h12, 32'h0,        32'h0000BEEF, 1'b0);
    issue2(W, SH, 8'h12, 32'h00001234, 32'h0000BEEF, 1'b0);
    issue2(R, SW, 8'h10, 32'h0,        32'hDEAD1234, 1'b0);
    issue2(R, SW, 8'h13, 32'h0,        32'h00000000, 1'b1);
    issue2(W, SH, 8'h11, 32'h0000FFFF, 32'h00000000, 1'b1);
    issue2(R, SW, 8'h10, 32'h0,        32'hDEAD1234, 1'b0);
    issue2(W, SB, 8'h10, 32'h0000005A, 32'hDEAD1234, 1'b0);
    issue2(R, SW, 8'h10, 32'h0,        32'h5AAD1234, 1'b0);
    issue2(R, SX, 8'h10, 32'h0,        32'h00000000, 1'b1);
    issue2(W, SW, 8'hFC, 32'h01020304, 32'h00000000, 1'b0);
    issue2(R, SB, 8'hFF, 32'h0,        32'h00000004, 1'b0);
    issue2(R, SH, 8'hFE, 32'h0,        32'h00000304, 1'b0);
    issue2(W, SW, 8'h20, 32'h11223344, 32'h00000304, 1'b0);

    // Request without enable is ignored.
    req2 = 1'b1; ctrl2 = 4'b0010; a2 = 8'h10;
    #1 chk("l2_busy_disabled_req", {31'b0, busy2}, 32'd0);
    repeat (4) tick();
    req2 = 1'b0; ctrl2 = '0; a2 = '0;
    tick();

    issue2(R, SW, 8'h20, 32'h0, 32'h11223344, 1'b0);

    // Store abandoned by reset in its first WAIT cycle.
    req2 = 1'b1; ctrl2 = {1'b1, W, SW}; a2 = 8'h20; di2 = 32'hCAFEF00D;
    tick();
    req2 = 1'b0; ctrl2 = '0; a2 = '0; di2 = '0;
    rst_b = 1'b0;
    tick();
    chk("abort_do", do2, 32'd0);
    chk("abort_ack", {31'b0, ack2}, 32'd0);
    chk("abort_busy", {31'b0, busy2}, 32'd0);
    chk("abort_err", {31'b0, err2}, 32'd0);
    rst_b = 1'b1;
    tick();
    chk("abort_idle_ack", {31'b0, ack2}, 32'd0);
    chk("abort_idle_busy", {31'b0, busy2}, 32'd0);
    repeat (4) tick();
    issue2(R, SW, 8'h20, 32'h0, 32'h11223344, 1'b0);

    // LATENCY=0: REQ held 4 cycles, store then load; REQ during RESP ignored.
    req0 = 1'b1; ctrl0 = {1'b1, W, SW}; a0 = 8'h40; di0 = 32'hA5A50F0F;
    #1 chk("l0_busy_on_store_req", {31'b0, busy0}, 32'd1);
    tick();
    e.cyc = cyc; e.d = 32'h00000000; e.e = 1'b0;
    q0.push_back(e);
    ctrl0 = {1'b1, R, SW}; a0 = 8'h40; di0 = '0;
    chk("l0_busy_resp_req_high", {31'b0, busy0}, 32'd0);
    tick();
    chk("l0_busy_idle_req_high", {31'b0, busy0}, 32'd1);
    tick();
    e.cyc = cyc; e.d = 32'hA5A50F0F; e.e = 1'b0;
    q0.push_back(e);
    tick();
    req0 = 1'b0; ctrl0 = '0; a0 = '0;
    repeat (4) tick();

    chk("l2_outstanding", q2.size(), 32'd0);
    chk("l0_outstanding", q0.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule

// File: doc/data_ram_responder.md
DATA_RAM_RESPONDER -- requirements
Module: data_ram_responder

Interface
REQ-001 Parameter: LATENCY, default 2, wait-state cycles between request acceptance and response (0..15).
REQ-002 Port: Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: Rst  input  1  reset; one clock, synchronous, active-low.
REQ-004 Port: REQ  input  1  MEM-stage access request, sampled in IDLE only.
REQ-005 Port: RAM_CTRL  input  4  [3]=enable, [2]=RW (1 store, 0 load), [1:0]=size (00 byte, 01 halfword, 10 word, 11 reserved).
REQ-006 Port: A  input  8  byte address into 256-byte data space.
REQ-007 Port: DI  input  32  store data, right-justified for byte/halfword.
REQ-008 Port: DO  output  32  load data, zero-extended.
REQ-009 Port: ACK  output  1  one-cycle response strobe.
REQ-010 Port: BUSY  output  1  pipeline stall request.
REQ-011 Port: ERR  output  1  alignment/size error, valid with ACK.

Function
REQ-012 Request accepted at a rising edge when state=IDLE, REQ=1, RAM_CTRL[3]=1; A, DI, RAM_CTRL captured into internal registers at that edge.
REQ-013 REQ=1 with RAM_CTRL[3]=0 is ignored; state stays IDLE.
REQ-014 FSM states: IDLE, WAIT, RESP; IDLE->WAIT on acceptance when LATENCY>0, IDLE->RESP when LATENCY=0; WAIT->RESP after LATENCY cycles in WAIT; RESP->IDLE unconditionally.
REQ-015 Wait counter loaded with LATENCY-1 on acceptance, decrements in WAIT, exits at zero; no wrap.
REQ-016 ACK=1 exactly in RESP, i.e. LATENCY+1 cycles after the acceptance edge; ACK never high two consecutive cycles.
REQ-017 BUSY=1 when state=WAIT, or state=IDLE with a qualifying request pending combinationally; BUSY=0 in RESP so pipeline advances on the ACK cycle.
REQ-018 REQ asserted in WAIT or RESP is ignored; no queuing.
REQ-019 Byte order big-endian: word at A holds bytes A(MSB)..A+3(LSB); halfword at A holds A(MSB), A+1.
REQ-020 Alignment: halfword requires A[0]=0, word requires A[1:0]=00; size 11 is an error.
REQ-021 Store memory commit occurs only at the edge entering RESP; only addressed bytes modified.
REQ-022 Load: DO updated at edge entering RESP with zero-extended data; DO holds value until next load response.
REQ-023 Store response leaves DO unchanged.
REQ-024 Error access: ERR=1 with ACK, no memory write, DO forced to 0x00000000.
REQ-025 ERR=0 whenever ACK=0.
REQ-026 Address arithmetic 8-bit; aligned accesses never cross 0xFF.

Reset
REQ-027 Rst=0 at a rising edge: state=IDLE, counter=0, DO=0x00000000, ACK=0, BUSY=0, ERR=0.
REQ-028 Reset in WAIT abandons the access; pending store is not committed.
REQ-029 Memory array contents are not cleared by reset.
REQ-030 Rst=0 overrides a simultaneous REQ.

Structure
REQ-031 Shared constants file holds RAM_CTRL field positions, size codes, FSM state encodings; CPU control unit uses the same file.
REQ-032 One sub-module, ram_byte_array: 256x8 storage, synchronous 4-byte-lane write enables, combinational 4-byte read.
REQ-033 FSM, counter, alignment check, lane steering, and extension live in data_ram_responder.

Verification
REQ-034 LATENCY=2; store word 0xDEADBEEF at A=0x10, then load word 0x10 -> ACK 3 cycles after each acceptance, DO=0xDEADBEEF, ERR=0.
REQ-035 After REQ-034, load byte A=0x11 -> DO=0x000000AD; load halfword A=0x12 -> DO=0x0000BEEF.
REQ-036 Store halfword DI=0x00001234 at A=0x12, load word 0x10 -> DO=0xDEAD1234.
REQ-037 Load word A=0x13, then store halfword A=0x11 -> each ACK with ERR=1, DO=0x00000000, memory at 0x10 still 0xDEAD1234.
REQ-038 Store word 0xCAFEF00D at 0x20, Rst=0 in first WAIT cycle -> outputs zero, IDLE next cycle; subsequent load 0x20 returns prior contents.
REQ-039 LATENCY=0 with REQ held high 4 cycles, store then load -> ACK alternates every other cycle, second REQ during RESP ignored, BUSY never high in RESP.
